targets_print_queue: RTL and testbench
======================================

Name: targets_print_queue

Overview:
- Parametrised successor to the single-target printer path: samples live target coordinates and keeps a circular queue of up to SLOTS committed targets.
- On a start pulse, streams every queued entry and then the live entry to the character display buffer, one character per clock.
- Sits between the target/coordinate logic and the text-mode display character RAM.
- Adds a real FIFO with occupancy, overwrite or drop policy, clear, empty-row blanking, and a write-enable strobe.

Parameters:
- SLOTS, 3, number of queued target entries (1..15).
- DIGITS, 4, hex digits per coordinate.
- COORD_W, 32, coordinate input width. Must equal 8*DIGITS; digit k is coord[8k+3:8k], most significant digit printed first.
- IDX_W, 8, character index width.
- SLOT_BASE, 176, character index of the first character of queue row 0.
- ROW_STRIDE, 32, index distance between queue rows.
- LIVE_BASE, 116, character index of the first character of the live row.
- OVERWRITE, 1, 1 = push when full replaces the oldest entry; 0 = push when full is dropped.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- resetn  in  1  asynchronous active-low reset.
- targetx  in  COORD_W  live target x, packed hex digits.
- targety  in  COORD_W  live target y, packed hex digits.
- queue_push  in  1  level input; each rising edge commits the live entry.
- clear  in  1  synchronous queue flush.
- start  in  1  print request.
- char_we  out  1  character write strobe.
- char_index  out  IDX_W  character RAM address.
- char_data  out  8  ASCII code.
- busy  out  1  print sweep in progress.
- finish  out  1  high when idle (not busy).
- done  out  1  one-cycle pulse after the last character write.
- level  out  4  number of valid queue entries (0..SLOTS).
- full  out  1  level==SLOTS.
- overflow  out  1  one-cycle pulse when a push hits a full queue.

Behaviour:
- Reset values (async, resetn=0): char_we=0, char_index=LIVE_BASE, char_data=0x00, busy=0, done=0, overflow=0, level=0, queue head/tail=0, live register=all 0x30, push edge detector=0, pending push=0. finish is therefore 1.
- ASCII conversion: nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46.
- Live register: loaded every clock with the converted targetx then targety digits, 2*DIGITS characters. One-cycle latency.
- Push event: a cycle where queue_push=1 and the queue_push value registered at the previous edge is 0. The entry written is the live register content at that edge, i.e. coordinates sampled one clock earlier.
- Push when not full: write at tail, tail wraps to 0 after SLOTS-1, level increments.
- Push when full: overflow pulses for 1 cycle.
  - OVERWRITE=1: write at tail, advance head and tail, level unchanged.
  - OVERWRITE=0: entry discarded, no state change.
- clear: head=tail=level=0, pending push dropped.
  - If busy, the sweep aborts the same cycle: busy=0, char_we=0, no done pulse.
  - clear wins over a simultaneous push or start.
- Push during busy: held in a one-deep pending flag and applied in the cycle done is high. A second push while one is pending is lost without overflow. The queue content therefore stays frozen for the whole sweep.
- FSM IDLE -> PRINT -> IDLE:
  - IDLE with start=1 and clear=0: capture level and head, row=0, col=0, busy=1.
  - PRINT, every cycle: char_we=1, char_data=character col of the row's entry. Let j=col and off=j+(j>>1), i.e. one blank column after every pair.
    - Queue rows r<SLOTS: char_index=SLOT_BASE+r*ROW_STRIDE+off. Row r shows the r-th oldest entry, queue[(head+r) mod SLOTS]. If r >= captured level, char_data=0x20 (space).
    - Live row, printed last: char_index=LIVE_BASE+off, char_data taken from the live register current value.
  - Index arithmetic is modulo 2^IDX_W.
  - First write occurs the cycle after start is seen. Total writes = (SLOTS+1)*2*DIGITS consecutive cycles.
  - After the last write: busy=0, char_we=0, done=1 for one cycle, return to IDLE. char_index and char_data hold their last values.
- start while busy is ignored. A start held high in IDLE retriggers a sweep on the cycle after done.
- Reset asserted mid-sweep: immediate return to the reset values above. No done pulse.

Test Plan:
- Reset, then start with empty queue, targetx=0x01020304, targety=0x0A0B0C0D, SLOTS=3, DIGITS=4 -> 32 writes. Rows 176/208/240 all data 0x20. Live indices 116,117,119,120,122,123,125,126 carry "1234ABCD". done pulses at cycle 33; finish=1 after.
- Push 4 distinct targets (x=1,2,3,4 in low digit) with OVERWRITE=1 -> overflow pulses on the 4th push, level=3. The sweep shows row 176 ends "2", row 208 "3", row 240 "4".
- Same sequence with OVERWRITE=0 -> overflow on the 4th push. Rows show targets 1,2,3.
- Raise queue_push mid-sweep -> level unchanged until done, then level+1. The sweep output matches the pre-push snapshot.
- Hold queue_push high for 10 cycles -> exactly one push, level=1.
- Assert clear at write 5 of a sweep -> char_we drops the next cycle, no done pulse, level=0. Separately, deassert resetn mid-sweep -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/targets_print_queue.sv
// Target print queue: samples live target coordinates, keeps a circular FIFO of
// committed targets and streams every queue row plus the live row to character RAM.
module targets_print_queue #(
    parameter int SLOTS      = 3,
    parameter int DIGITS     = 4,
    parameter int COORD_W    = 32,
    parameter int IDX_W      = 8,
    parameter int SLOT_BASE  = 176,
    parameter int ROW_STRIDE = 32,
    parameter int LIVE_BASE  = 116,
    parameter bit OVERWRITE  = 1'b1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [COORD_W-1:0] targetx,
    input  logic [COORD_W-1:0] targety,
    input  logic               queue_push,
    input  logic               clear,
    input  logic               start,
    output logic               char_we,
    output logic [IDX_W-1:0]   char_index,
    output logic [7:0]         char_data,
    output logic               busy,
    output logic               finish,
    output logic               done,
    output logic [3:0]         level,
    output logic               full,
    output logic               overflow
);
    localparam int CHARS = 2 * DIGITS;
    localparam int COL_W = $clog2(CHARS);
    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [3:0] SLOTS_L = 4'(SLOTS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(CHARS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SLOTS - 1);

    typedef enum logic {IDLE, PRINT} state_t;
    typedef logic [CHARS-1:0][7:0] row_t;

    state_t           state;
    row_t             live_p1, live_next;
    row_t             queue_mem [SLOTS];
    logic [PTR_W-1:0] head, tail, cap_head, sel_head, slot;
    logic [3:0]       cap_level, sel_level, row, nxt_row;
    logic [COL_W-1:0] col, nxt_col;
    logic             push_p1, pend, push_evt, do_push, write_en, last_char;
    logic [IDX_W-1:0] nxt_index;
    logic [7:0]       nxt_data;
    int               off, slot_sum;
    logic             unused_coord_bits;

    function automatic logic [7:0] to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Only the low nibble of every coordinate byte carries a digit.
    assign unused_coord_bits = ^{targetx, targety};

    always_comb begin
        live_next = '0;
        for (int k = 0; k < DIGITS; k++) begin
            live_next[k]          = to_ascii(targetx[8*(DIGITS-1-k) +: 4]);
            live_next[DIGITS + k] = to_ascii(targety[8*(DIGITS-1-k) +: 4]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) live_p1 <= {CHARS{8'h30}};
        else         live_p1 <= live_next;
    end

    assign busy     = (state == PRINT);
    assign finish   = ~busy;
    assign full     = (level == SLOTS_L);
    assign push_evt = queue_push & ~push_p1;
    // A push deferred during a sweep lands on the done cycle.
    assign do_push  = ~clear & ((push_evt & ~busy) | (pend & done));
    assign write_en = do_push & (~full | OVERWRITE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            head     <= '0;
            tail     <= '0;
            level    <= 4'd0;
            overflow <= 1'b0;
            pend     <= 1'b0;
            push_p1  <= 1'b0;
        end else begin
            push_p1  <= queue_push;
            overflow <= do_push & full;
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                level <= 4'd0;
                pend  <= 1'b0;
            end else begin
                if (busy && push_evt) pend <= 1'b1;
                else if (done)        pend <= 1'b0;
                if (do_push) begin
                    if (!full) begin
                        tail  <= next_ptr(tail);
                        level <= level + 4'd1;
                    end else if (OVERWRITE) begin
                        head <= next_ptr(head);
                        tail <= next_ptr(tail);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (write_en) queue_mem[tail] <= live_p1;
    end

    // Character for the next write: in IDLE it is the first one of a sweep.
    always_comb begin
        sel_level = busy ? cap_level : level;
        sel_head  = busy ? cap_head : head;
        nxt_row   = 4'd0;
        nxt_col   = '0;
        if (busy) begin
            if (col == LAST_COL) begin
                nxt_row = row + 4'd1;
            end else begin
                nxt_row = row;
                nxt_col = col + 1'b1;
            end
        end
        last_char = busy && (row == SLOTS_L) && (col == LAST_COL);
        off       = int'(nxt_col) + int'(nxt_col >> 1);
        slot_sum  = int'(sel_head) + int'(nxt_row);
        if (slot_sum >= SLOTS) slot_sum = slot_sum - SLOTS;
        slot = PTR_W'(slot_sum);
        if (nxt_row == SLOTS_L) begin
            nxt_index = IDX_W'(LIVE_BASE + off);
            nxt_data  = live_p1[nxt_col];
        end else begin
            nxt_index = IDX_W'(SLOT_BASE + int'(nxt_row) * ROW_STRIDE + off);
            nxt_data  = (nxt_row < sel_level) ? queue_mem[slot][nxt_col] : 8'h20;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            char_we    <= 1'b0;
            char_index <= IDX_W'(LIVE_BASE);
            char_data  <= 8'h00;
            done       <= 1'b0;
            row        <= 4'd0;
            col        <= '0;
            cap_level  <= 4'd0;
            cap_head   <= '0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state   <= IDLE;
                char_we <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= PRINT;
                            cap_level  <= level;
                            cap_head   <= head;
                            row        <= nxt_row;
                            col        <= nxt_col;
                            char_we    <= 1'b1;
                            char_index <= nxt_index;
                            char_data  <= nxt_data;
                        end
                    end
                    PRINT: begin
                        if (last_char) begin
                            state   <= IDLE;
                            char_we <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            row        <= nxt_row;
                            col        <= nxt_col;
                            char_index <= nxt_index;
                            char_data  <= nxt_data;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_targets_print_queue.sv
// Bench for targets_print_queue: an overwrite-policy and a drop-policy instance share
// stimulus; expected character writes are queued at start and popped per write.
`timescale 1ns/1ps
module tb_targets_print_queue;
    typedef struct packed { logic [7:0] idx; logic [7:0] data; } wr_t;
    typedef struct { logic [31:0] x; logic [3:0] lvl_a; logic ovf_a; logic [3:0] lvl_b; logic ovf_b; } push_vec_t;

    logic        clock = 1'b0, resetn = 1'b0;
    logic [31:0] targetx = '0, targety = '0;
    logic        queue_push = 1'b0, clear = 1'b0, start = 1'b0;
    logic        we_a, busy_a, finish_a, done_a, full_a, ovf_a;
    logic        we_b, busy_b, finish_b, done_b, full_b, ovf_b;
    logic [7:0]  idx_a, data_a, idx_b, data_b;
    logic [3:0]  level_a, level_b;

    int          errors = 0, checks = 0;
    int          nw_a = 0, nw_b = 0;
    wr_t         exp_a[$], exp_b[$];
    wr_t         e_a, e_b;
    logic [63:0] mq_a[$], mq_b[$];
    string       hexs = "0123456789ABCDEF";
    push_vec_t   pv[4];

    always #5 clock = ~clock;

    targets_print_queue #(.OVERWRITE(1'b1)) dut_a (
        .clock(clock), .resetn(resetn), .targetx(targetx), .targety(targety),
        .queue_push(queue_push), .clear(clear), .start(start),
        .char_we(we_a), .char_index(idx_a), .char_data(data_a), .busy(busy_a),
        .finish(finish_a), .done(done_a), .level(level_a), .full(full_a), .overflow(ovf_a));

    targets_print_queue #(.OVERWRITE(1'b0)) dut_b (
        .clock(clock), .resetn(resetn), .targetx(targetx), .targety(targety),
        .queue_push(queue_push), .clear(clear), .start(start),
        .char_we(we_b), .char_index(idx_b), .char_data(data_b), .busy(busy_b),
        .finish(finish_b), .done(done_b), .level(level_b), .full(full_b), .overflow(ovf_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (resetn && we_a) begin
            nw_a++;
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL write_a: unexpected write idx %0d data %0h", idx_a, data_a);
            end else begin
                e_a = exp_a.pop_front();
                check("write_a", {16'h0, idx_a, data_a}, {16'h0, e_a});
            end
        end
        if (resetn && we_b) begin
            nw_b++;
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL write_b: unexpected write idx %0d data %0h", idx_b, data_b);
            end else begin
                e_b = exp_b.pop_front();
                check("write_b", {16'h0, idx_b, data_b}, {16'h0, e_b});
            end
        end
    end

    function automatic logic [63:0] chars_of(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8]     = hexs[x[(24 - 8*k) +: 4]];
            r[8*(4+k) +: 8] = hexs[y[(24 - 8*k) +: 4]];
        end
        return r;
    endfunction

    task automatic load_expect();
        logic [63:0] live;
        logic [63:0] t;
        wr_t ea, eb;
        live = chars_of(targetx, targety);
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 8; j++) begin
                if (r == 3) begin
                    ea.idx = 8'(116 + j + j/2);
                    ea.data = live[8*j +: 8];
                    eb = ea;
                end else begin
                    ea.idx = 8'(176 + 32*r + j + j/2);
                    eb.idx = ea.idx;
                    ea.data = 8'h20;
                    eb.data = 8'h20;
                    if (r < mq_a.size()) begin t = mq_a[r]; ea.data = t[8*j +: 8]; end
                    if (r < mq_b.size()) begin t = mq_b[r]; eb.data = t[8*j +: 8]; end
                end
                exp_a.push_back(ea);
                exp_b.push_back(eb);
            end
        end
    endtask

    task automatic model_push();
        logic [63:0] e, tmp;
        e = chars_of(targetx, targety);
        if (mq_a.size() == 3) tmp = mq_a.pop_front();
        mq_a.push_back(e);
        if (mq_b.size() < 3) mq_b.push_back(e);
    endtask

    task automatic model_clear();
        mq_a.delete();
        mq_b.delete();
    endtask

    task automatic push_pulse(output logic o_a, output logic o_b);
        @(posedge clock); #1 queue_push = 1'b1;
        @(posedge clock); #1 queue_push = 1'b0;
        model_push();
        o_a = ovf_a;
        o_b = ovf_b;
    endtask

    task automatic clear_pulse();
        @(posedge clock); #1 clear = 1'b1;
        @(posedge clock); #1 clear = 1'b0;
        model_clear();
        check("clear_level_a", level_a, 0);
        check("clear_level_b", level_b, 0);
        check("clear_full_a", full_a, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"}, we_a, 0);
        check({tag, "_index"}, idx_a, 116);
        check({tag, "_data"}, data_a, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_finish"}, finish_a, 1);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_ovf"}, ovf_a, 0);
        check({tag, "_level"}, level_a, 0);
        check({tag, "_full"}, full_a, 0);
        check({tag, "_b"}, {we_b, busy_b, done_b, ovf_b, level_b, idx_b}, {4'b0000, 4'd0, 8'd116});
    endtask

    task automatic sweep(input bit mid_push);
        int n;
        bit seen;
        logic [3:0] lvl0_a, lvl0_b;
        lvl0_a = level_a;
        lvl0_b = level_b;
        load_expect();
        nw_a = 0; nw_b = 0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(negedge clock);
            n++;
            if (done_a) seen = 1;
            if (mid_push && n == 10) queue_push = 1'b1;
            if (mid_push && n == 11) queue_push = 1'b0;
            if (mid_push && n == 20) begin
                check("frozen_level_a", level_a, lvl0_a);
                check("frozen_level_b", level_b, lvl0_b);
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end
        check("done_cycle", n, 33);
        check("done_b", done_b, 1);
        check("writes_a", nw_a, 32);
        check("writes_b", nw_b, 32);
        check("exp_left_a", exp_a.size(), 0);
        check("exp_left_b", exp_b.size(), 0);
        @(negedge clock);
        check("after_finish", finish_a, 1);
        check("after_done", done_a, 0);
        if (mid_push) begin
            model_push();
            check("pend_level_a", level_a, lvl0_a + 4'd1);
            check("pend_level_b", level_b, lvl0_b + 4'd1);
        end
    endtask

    task automatic abort_sweep(input bit by_reset);
        int dcount;
        load_expect();
        nw_a = 0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (by_reset ? 10 : 5) @(negedge clock);
        if (!by_reset) begin
            clear = 1'b1;
            @(negedge clock);
            clear = 1'b0;
            check("abort_we", we_a, 0);
            check("abort_busy", busy_a, 0);
            check("abort_level_a", level_a, 0);
            check("abort_level_b", level_b, 0);
            check("abort_writes", nw_a, 5);
            dcount = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (done_a || we_a) dcount++;
            end
            check("abort_no_done", dcount, 0);
        end else begin
            resetn = 1'b0;
            #1 check_reset("midrst");
            @(posedge clock); #1 resetn = 1'b1;
        end
        model_clear();
        exp_a.delete();
        exp_b.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic oa, ob;
        int ovf_count;
        pv[0] = '{32'h00000001, 4'd1, 1'b0, 4'd1, 1'b0};
        pv[1] = '{32'h00000002, 4'd2, 1'b0, 4'd2, 1'b0};
        pv[2] = '{32'h00000003, 4'd3, 1'b0, 4'd3, 1'b0};
        pv[3] = '{32'h00000004, 4'd3, 1'b1, 4'd3, 1'b1};

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset("reset");
        @(posedge clock); #1 resetn = 1'b1;

        // Empty queue: rows blank, live row "1234ABCD".
        targetx = 32'h01020304;
        targety = 32'h0A0B0C0D;
        repeat (2) @(posedge clock);
        sweep(1'b0);

        // Four pushes into three slots under both policies.
        targety = 32'h0F0E0D0C;
        for (int i = 0; i < 4; i++) begin
            targetx = pv[i].x;
            @(posedge clock);
            push_pulse(oa, ob);
            check($sformatf("push%0d_level_a", i), level_a, pv[i].lvl_a);
            check($sformatf("push%0d_ovf_a", i), oa, pv[i].ovf_a);
            check($sformatf("push%0d_level_b", i), level_b, pv[i].lvl_b);
            check($sformatf("push%0d_ovf_b", i), ob, pv[i].ovf_b);
            check($sformatf("push%0d_full_a", i), full_a, pv[i].lvl_a == 4'd3);
        end
        targetx = 32'h00000909;
        repeat (2) @(posedge clock);
        sweep(1'b0);

        // Push raised mid-sweep is deferred to the done cycle.
        clear_pulse();
        targetx = 32'h00000005;
        push_pulse(oa, ob);
        check("p5_level_a", level_a, 1);
        sweep(1'b1);

        // Held push level commits exactly once.
        clear_pulse();
        ovf_count = 0;
        @(posedge clock); #1 queue_push = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (ovf_a || ovf_b) ovf_count++;
        end
        queue_push = 1'b0;
        model_push();
        check("hold_level_a", level_a, 1);
        check("hold_level_b", level_b, 1);
        check("hold_no_ovf", ovf_count, 0);

        abort_sweep(1'b0);
        push_pulse(oa, ob);
        abort_sweep(1'b1);

        // Normal operation after the mid-sweep reset.
        repeat (2) @(posedge clock);
        sweep(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
